// File: rtl/stash_sequencer_if.sv
// rtl/stash_sequencer_if.sv - Button/producer inputs and Stash control outputs of the stash sequencer.
interface stash_sequencer_if #(
   parameter int POS_W = 3
);
   logic             src_valid;
   logic             btn_hold;
   logic             btn_next;
   logic             btn_auto;
   logic             stash_write;
   logic             stash_next;
   logic [1:0]       mode;
   logic [POS_W-1:0] browse_pos;
   logic [7:0]       dropped_cnt;

   modport master (
      input  src_valid, btn_hold, btn_next, btn_auto,
      output stash_write, stash_next, mode, browse_pos, dropped_cnt
   );

   modport slave (
      output src_valid, btn_hold, btn_next, btn_auto,
      input  stash_write, stash_next, mode, browse_pos, dropped_cnt
   );
endinterface

// File: rtl/stash_sequencer.sv
// rtl/stash_sequencer.sv - LIVE/BROWSE/AUTO sequencer driving Stash write/next strobes.
// Optional button debounce filter enabled by defining STASH_SEQ_DEBOUNCE_EN.
module stash_sequencer #(
   parameter  int DEPTH           = 5,
   parameter  int AUTO_PERIOD     = 50000000,
`ifdef STASH_SEQ_DEBOUNCE_EN
   parameter  int DEBOUNCE_CYCLES = 1000000,
`endif
   localparam int POS_W           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input logic               clk,
   input logic               reset,
   stash_sequencer_if.master bus
);
   localparam int TMR_W = $clog2(AUTO_PERIOD);

   typedef enum logic [1:0] {
      LIVE   = 2'b00,
      BROWSE = 2'b01,
      AUTO   = 2'b10
   } mode_e;

   logic [2:0] btn_raw;
   logic [2:0] sync1_q, sync2_q;
   logic [2:0] level;
   logic [2:0] level_prev_q;
   logic [2:0] ev;
   logic       ev_hold, ev_next, ev_auto;

   assign btn_raw = {bus.btn_auto, bus.btn_next, bus.btn_hold};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

`ifdef STASH_SEQ_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [2:0]      filt_q;
   logic [DB_W-1:0] db_cnt_q [3];

   // Filtered level follows the synchronised level only after DEBOUNCE_CYCLES differing samples in a row.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_q <= '0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               filt_q[i]   <= sync2_q[i];
               db_cnt_q[i] <= '0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign level = filt_q;
`else
   assign level = sync2_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) level_prev_q <= '0;
      else       level_prev_q <= level;
   end

   assign ev      = level & ~level_prev_q;
   assign ev_hold = ev[0];
   assign ev_next = ev[1];
   assign ev_auto = ev[2];

   mode_e            mode_q, mode_d;
   logic             write_q, write_d;
   logic             next_q, next_d;
   logic [POS_W-1:0] pos_q, pos_d, pos_inc;
   logic [7:0]       drop_q, drop_d, drop_inc;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [POS_W-1:0] rev_q, rev_d;
   logic             pend_q, pend_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q  <= LIVE;
         write_q <= 1'b0;
         next_q  <= 1'b0;
         pos_q   <= '0;
         drop_q  <= '0;
         timer_q <= '0;
         rev_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         write_q <= write_d;
         next_q  <= next_d;
         pos_q   <= pos_d;
         drop_q  <= drop_d;
         timer_q <= timer_d;
         rev_q   <= rev_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      mode_d   = mode_q;
      write_d  = 1'b0;
      next_d   = 1'b0;
      pos_d    = pos_q;
      drop_d   = drop_q;
      timer_d  = timer_q;
      rev_d    = rev_q;
      pend_d   = pend_q;
      drop_inc = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
      pos_inc  = (pos_q == POS_W'(DEPTH - 1)) ? '0 : pos_q + 1'b1;

      case (mode_q)
         LIVE: begin
            write_d = bus.src_valid;
            pend_d  = 1'b0;
            timer_d = '0;
            if (ev_hold) begin
               mode_d = BROWSE;
               pos_d  = '0;
            end else if (ev_auto) begin
               mode_d = AUTO;
               pos_d  = '0;
               rev_d  = '0;
            end
         end
         BROWSE: begin
            if (bus.src_valid) drop_d = drop_inc;
            if (ev_hold) begin
               mode_d = LIVE;
               pos_d  = '0;
               drop_d = '0;
               pend_d = 1'b0;
            end else if (ev_auto) begin
               mode_d  = AUTO;
               timer_d = '0;
               rev_d   = '0;
               pend_d  = 1'b0;
            end else if (ev_next || pend_q) begin
               // A step requested while the previous pulse is still high waits one cycle.
               if (next_q) begin
                  pend_d = 1'b1;
               end else begin
                  next_d = 1'b1;
                  pos_d  = pos_inc;
                  pend_d = 1'b0;
               end
            end
         end
         AUTO: begin
            if (bus.src_valid) drop_d = drop_inc;
            if (ev_hold) begin
               mode_d  = LIVE;
               pos_d   = '0;
               drop_d  = '0;
               timer_d = '0;
            end else if (ev_auto) begin
               mode_d  = BROWSE;
               timer_d = '0;
            end else if (timer_q == TMR_W'(AUTO_PERIOD - 1)) begin
               next_d  = 1'b1;
               pos_d   = pos_inc;
               timer_d = '0;
               rev_d   = rev_q + 1'b1;
               if (rev_q == POS_W'(DEPTH - 1)) mode_d = BROWSE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            mode_d  = LIVE;
            pos_d   = '0;
            drop_d  = '0;
            timer_d = '0;
            pend_d  = 1'b0;
         end
      endcase
   end

   assign bus.stash_write = write_q;
   assign bus.stash_next  = next_q;
   assign bus.mode        = mode_q;
   assign bus.browse_pos  = pos_q;
   assign bus.dropped_cnt = drop_q;
endmodule

// File: tb/tb_stash_sequencer.sv
// tb/tb_stash_sequencer.sv - Directed self-checking bench for stash_sequencer (DEPTH=5, AUTO_PERIOD=4).
module tb_stash_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   stash_sequencer_if #(.POS_W(3)) bus ();

   stash_sequencer #(
      .DEPTH       (5),
      .AUTO_PERIOD (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives {auto,next,hold} for 4 cycles, releases for 4, returns the stash_next samples seen.
   task automatic press(input logic [2:0] b, output int pulses);
      pulses = 0;
      {bus.btn_auto, bus.btn_next, bus.btn_hold} = b;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) {bus.btn_auto, bus.btn_next, bus.btn_hold} = 3'b000;
         step();
         if (bus.stash_next) pulses++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.src_valid = 1'b0;
      {bus.btn_auto, bus.btn_next, bus.btn_hold} = 3'b000;
      step();
      step();
      checks++;
      if ({bus.stash_write, bus.stash_next, bus.mode, bus.browse_pos, bus.dropped_cnt} !== 15'd0) begin
         errors++;
         $display("FAIL reset_state got w=%b n=%b mode=%b pos=%0d drop=%0d expected all zero",
                  bus.stash_write, bus.stash_next, bus.mode, bus.browse_pos, bus.dropped_cnt);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_live_write();
      int writes = 0;
      bus.src_valid = 1'b1;
      checks++;
      if (bus.stash_write !== 1'b0) begin
         errors++;
         $display("FAIL live_latency got stash_write=%b before first edge, expected 0", bus.stash_write);
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 7) bus.src_valid = 1'b0;
         step();
         if (bus.stash_write) writes++;
         if (i == 0) begin
            checks++;
            if (bus.stash_write !== 1'b1) begin
               errors++;
               $display("FAIL live_first_write got %b expected 1", bus.stash_write);
            end
         end
         if (bus.stash_write && bus.stash_next) begin
            checks++;
            errors++;
            $display("FAIL write_next_exclusive got both high expected never both");
         end
      end
      checks++;
      if (writes !== 7) begin
         errors++;
         $display("FAIL live_write_count got %0d expected 7", writes);
      end
      checks++;
      if (bus.mode !== 2'b00 || bus.dropped_cnt !== 8'd0) begin
         errors++;
         $display("FAIL live_state got mode=%b drop=%0d expected mode=00 drop=0", bus.mode, bus.dropped_cnt);
      end
   endtask

   task automatic test_hold_drop();
      int writes = 0;
      bus.btn_hold = 1'b1;
      step();
      step();
      checks++;
      if (bus.mode !== 2'b00) begin
         errors++;
         $display("FAIL hold_early got mode=%b after 2 cycles expected 00", bus.mode);
      end
      step();
      checks++;
      if (bus.mode !== 2'b01) begin
         errors++;
         $display("FAIL hold_latency got mode=%b after 3 cycles expected 01", bus.mode);
      end
      step();
      bus.btn_hold = 1'b0;
      for (int i = 0; i < 4; i++) step();
      bus.src_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.stash_write) writes++;
      end
      bus.src_valid = 1'b0;
      step();
      if (bus.stash_write) writes++;
      checks++;
      if (writes !== 0 || bus.dropped_cnt !== 8'd3) begin
         errors++;
         $display("FAIL browse_drop got writes=%0d drop=%0d expected writes=0 drop=3", writes, bus.dropped_cnt);
      end
   endtask

   task automatic test_browse_next();
      int pulses;
      logic [2:0] exp_pos [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
      for (int k = 0; k < 6; k++) begin
         press(3'b010, pulses);
         checks++;
         if (pulses !== 1 || bus.browse_pos !== exp_pos[k]) begin
            errors++;
            $display("FAIL browse_next_%0d got pulses=%0d pos=%0d expected pulses=1 pos=%0d",
                     k, pulses, bus.browse_pos, exp_pos[k]);
         end
      end
      press(3'b001, pulses);
      checks++;
      if (bus.mode !== 2'b00 || bus.browse_pos !== 3'd0 || bus.dropped_cnt !== 8'd0 || pulses !== 0) begin
         errors++;
         $display("FAIL browse_to_live got mode=%b pos=%0d drop=%0d pulses=%0d expected 00/0/0/0",
                  bus.mode, bus.browse_pos, bus.dropped_cnt, pulses);
      end
   endtask

   task automatic test_auto();
      int pulse_at [$];
      bus.btn_auto = 1'b1;
      for (int s = 1; s <= 30; s++) begin
         if (s == 5) bus.btn_auto = 1'b0;
         step();
         if (s == 3) begin
            checks++;
            if (bus.mode !== 2'b10) begin
               errors++;
               $display("FAIL auto_entry got mode=%b expected 10", bus.mode);
            end
         end
         if (bus.stash_next) pulse_at.push_back(s);
      end
      checks++;
      if (pulse_at.size() !== 5) begin
         errors++;
         $display("FAIL auto_pulse_count got %0d expected 5", pulse_at.size());
      end
      for (int k = 0; k < pulse_at.size() && k < 5; k++) begin
         checks++;
         if (pulse_at[k] !== 7 + 4 * k) begin
            errors++;
            $display("FAIL auto_pulse_%0d got cycle %0d expected %0d", k, pulse_at[k], 7 + 4 * k);
         end
      end
      checks++;
      if (bus.mode !== 2'b01 || bus.browse_pos !== 3'd0) begin
         errors++;
         $display("FAIL auto_done got mode=%b pos=%0d expected 01/0", bus.mode, bus.browse_pos);
      end
   endtask

   task automatic test_same_cycle();
      int pulses;
      press(3'b011, pulses);
      checks++;
      if (bus.mode !== 2'b00 || pulses !== 0) begin
         errors++;
         $display("FAIL hold_beats_next got mode=%b pulses=%0d expected 00/0", bus.mode, pulses);
      end
   endtask

   task automatic test_reset_mid_auto();
      int pulses = 0;
      bus.btn_auto = 1'b1;
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (bus.mode !== 2'b10) begin
         errors++;
         $display("FAIL mid_auto_entry got mode=%b expected 10", bus.mode);
      end
      step();
      step();
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.stash_write, bus.stash_next, bus.mode, bus.browse_pos, bus.dropped_cnt} !== 15'd0) begin
         errors++;
         $display("FAIL async_reset got mode=%b pos=%0d n=%b expected all zero",
                  bus.mode, bus.browse_pos, bus.stash_next);
      end
      bus.btn_auto = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.stash_next) pulses++;
      end
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.stash_next) pulses++;
      end
      checks++;
      if (pulses !== 0 || bus.mode !== 2'b00) begin
         errors++;
         $display("FAIL reset_abort got pulses=%0d mode=%b expected 0/00", pulses, bus.mode);
      end
   endtask

   task automatic test_saturate();
      int pulses;
      int writes = 0;
      press(3'b001, pulses);
      checks++;
      if (bus.mode !== 2'b01) begin
         errors++;
         $display("FAIL sat_browse_entry got mode=%b expected 01", bus.mode);
      end
      bus.src_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (bus.stash_write) writes++;
      end
      bus.src_valid = 1'b0;
      step();
      checks++;
      if (bus.dropped_cnt !== 8'd255 || writes !== 0) begin
         errors++;
         $display("FAIL drop_saturate got drop=%0d writes=%0d expected 255/0", bus.dropped_cnt, writes);
      end
   endtask

   initial begin
      test_reset();
      test_live_write();
      test_hold_drop();
      test_browse_next();
      test_auto();
      test_same_cycle();
      test_reset_mid_auto();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
